seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits, legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match-counter width, legal range 1..32.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din is consumed on a rising edge only when this is 1.
REQ-007 pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the first bit received.
REQ-008 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 clear  input  1  synchronous flush of the window, fill count and state; the match counter is kept.
REQ-010 dout  output  1  Moore match flag, driven only from the state register.
REQ-011 match_count  output  CNT_W  number of matches since reset, saturating.
REQ-012 fill  output  $clog2(PAT_W+1)  number of valid bits currently in the window.

Function
REQ-013 Window update: on a valid bit, window SHALL become {window[PAT_W-2:0], din}, and fill SHALL increment, saturating at PAT_W.
REQ-014 FSM states:
  - IDLE: fill==0.
  - FILL: fill>0 and no match.
  - MATCH: dout=1.
  - In every state other than MATCH, dout SHALL be 0.
REQ-015 Match condition: a valid bit SHALL produce a match when the updated fill==PAT_W and the updated window==pattern. The next state is then MATCH.
REQ-016 Latency: dout SHALL be 1 in exactly the cycle after the edge that consumed the last pattern bit; din does not drive dout combinationally.
REQ-017 Leaving MATCH: MATCH SHALL last one cycle. The next state is MATCH again only if the next edge carries a valid bit that also produces a match; otherwise it is FILL, or IDLE if fill==0.
REQ-018 Non-overlapping (overlap_en=0): on a match, fill SHALL reset to 0, so the next match requires PAT_W fresh valid bits.
REQ-019 Overlapping (overlap_en=1): on a match, fill SHALL stay at PAT_W, so consecutive valid bits may produce back-to-back matches with dout held high.
REQ-020 Invalid cycles: when din_valid=0, window and fill SHALL hold. The state SHALL leave MATCH per REQ-017 and otherwise hold.
REQ-021 Dynamic inputs: pattern and overlap_en SHALL be sampled on every valid edge; a change takes effect on the next valid bit, with no flush.
REQ-022 Simultaneous events: when clear=1 and din_valid=1 on the same edge, clear SHALL win and the bit SHALL be discarded. reset SHALL override clear.
REQ-023 Clear: clear SHALL set window=0, fill=0 and state=IDLE on the next edge.
REQ-024 Counter: match_count SHALL increment by 1 on each match edge and SHALL saturate at 2^CNT_W-1 without wrap-around.

Reset
REQ-025 On a rising edge with reset=1, the block SHALL set:
  - state=IDLE, dout=0, window=0, fill=0, match_count=0.
  - All inputs are ignored during that edge.
REQ-026 Reset asserted mid-sequence or during MATCH SHALL discard partial matches; detection SHALL restart from IDLE on the first valid bit after reset deasserts.

Configuration
REQ-027 The feature macro SHALL be SEQDET_MATCH_CNT_EN.
REQ-028 With SEQDET_MATCH_CNT_EN defined, match_count SHALL behave per REQ-024.
REQ-029 Without SEQDET_MATCH_CNT_EN, match_count SHALL be constant 0, no counter register SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-030 PAT_W=4, pattern=4'b1010, overlap_en=0, din_valid=1, din=1,0,1,0,1,0,1,0 -> dout pulses one cycle after bits 4 and 8 only; match_count=2.
REQ-031 Same stimulus with overlap_en=1 -> dout pulses after bits 4, 6 and 8; match_count=3.
REQ-032 pattern=4'b1111, overlap_en=1, six consecutive 1s -> dout high for 3 consecutive cycles, starting the cycle after bit 4; overlap_en=0 -> one pulse only.
REQ-033 pattern=1010, bits 1,0,1, then din_valid=0 for 5 cycles, then bit 0 -> no dout during the gap; dout=1 one cycle after the final bit.
REQ-034 Bits 1,0,1, then clear=1 together with din_valid=1 and din=0 -> no match, fill=0. Separately, reset pulsed during MATCH -> dout=0, fill=0, match_count=0 on the next cycle.
REQ-035 CNT_W=2, overlap_en=1, pattern=1111, ten 1s -> match_count saturates at 3. Without SEQDET_MATCH_CNT_EN -> match_count stays 0 and dout is unchanged.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with Moore match flag, fill tracking and optional overlap.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
  parameter  int PAT_W  = 4,
  parameter  int CNT_W  = 8,
  localparam int FILL_W = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap_en,
  input  logic              clear,
  output logic              dout,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill
);

  // state | meaning
  // IDLE  | window empty (fill == 0)
  // FILL  | window holds bits, no match on the last edge
  // MATCH | last consumed bit completed the pattern; dout = 1
  typedef enum logic [1:0] {IDLE, FILL, MATCH} state_t;

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  state_t            state, state_nxt;
  logic [PAT_W-1:0]  window, window_nxt, shifted;
  logic [FILL_W-1:0] fill_nxt, fill_inc;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      window <= '0;
      fill   <= '0;
    end else begin
      state  <= state_nxt;
      window <= window_nxt;
      fill   <= fill_nxt;
    end
  end

  always_comb begin
    shifted    = {window[PAT_W-2:0], din};
    fill_inc   = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
    hit        = 1'b0;
    state_nxt  = state;
    window_nxt = window;
    fill_nxt   = fill;
    if (clear) begin
      state_nxt  = IDLE;
      window_nxt = '0;
      fill_nxt   = '0;
    end else if (din_valid) begin
      window_nxt = shifted;
      hit        = (fill_inc == FILL_MAX) && (shifted == pattern);
      if (hit) begin
        state_nxt = MATCH;
        // Non-overlapping mode demands a completely fresh pattern after a hit.
        fill_nxt  = overlap_en ? FILL_MAX : '0;
      end else begin
        state_nxt = FILL;
        fill_nxt  = fill_inc;
      end
    end else if (state == MATCH) begin
      state_nxt = (fill == '0) ? IDLE : FILL;
    end
  end

  assign dout = (state == MATCH);

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus randomized traffic
// compared every cycle against a bit-history reference model (two counter widths).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, din, din_valid, overlap_en, clear;
  logic [3:0] pattern;
  logic       dout, dout2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [2:0] fill, fill2;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  // reference model state
  int m_win, m_fill, m_cnt8, m_cnt2;
  bit m_dout;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pattern(pattern),
    .overlap_en(overlap_en), .clear(clear), .dout(dout), .match_count(match_count), .fill(fill)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pattern(pattern),
    .overlap_en(overlap_en), .clear(clear), .dout(dout2), .match_count(match_count2), .fill(fill2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference: keep the last four bits as a number and count how many are fresh.
  task automatic model_edge();
    bit matched;
    matched = 1'b0;
    if (reset) begin
      m_win = 0; m_fill = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (clear) begin
      m_win = 0; m_fill = 0;
    end else if (din_valid) begin
      m_win  = ((m_win * 2) + int'(din)) % 16;
      m_fill = (m_fill < 4) ? m_fill + 1 : 4;
      if (m_fill == 4 && m_win == int'(pattern)) begin
        matched = 1'b1;
        m_fill  = overlap_en ? 4 : 0;
`ifdef SEQDET_MATCH_CNT_EN
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
`endif
      end
    end
    m_dout = matched;
  endtask

  task automatic step(input logic d, input logic v, input logic c, input logic r);
    din = d; din_valid = v; clear = c; reset = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dout", 32'(dout), 32'(m_dout));
    chk("fill", 32'(fill), 32'(m_fill));
    chk("match_count", 32'(match_count), 32'(m_cnt8));
    chk("dout_w2", 32'(dout2), 32'(m_dout));
    chk("fill_w2", 32'(fill2), 32'(m_fill));
    chk("match_count_w2", 32'(match_count2), 32'(m_cnt2));
    if (dout) pulses++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulses = 0;
  endtask

  initial begin
    int exp_cnt;
    logic [7:0] alt;
    alt = 8'b1010_1010;
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    overlap_en = 1'b0; pattern = 4'b1010;
    m_win = 0; m_fill = 0; m_cnt8 = 0; m_cnt2 = 0; m_dout = 1'b0;
    @(negedge clk);

    // reset state
    do_reset();
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_fill", 32'(fill), 32'd0);

    // 1010 repeated, non-overlapping: pulses after bits 4 and 8
    pattern = 4'b1010; overlap_en = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      step(alt[i], 1'b1, 1'b0, 1'b0);
      chk("nonovl_dout_bit", 32'(dout), 32'((i == 4) || (i == 0)));
    end
    chk("nonovl_pulses", 32'(pulses), 32'd2);
`ifdef SEQDET_MATCH_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    chk("nonovl_count", 32'(match_count), 32'(exp_cnt));

    // same stimulus, overlapping: pulses after bits 4, 6 and 8
    do_reset();
    overlap_en = 1'b1;
    for (int i = 7; i >= 0; i--) step(alt[i], 1'b1, 1'b0, 1'b0);
    chk("ovl_pulses", 32'(pulses), 32'd3);
`ifdef SEQDET_MATCH_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    chk("ovl_count", 32'(match_count), 32'(exp_cnt));

    // 1111 with six ones: three back-to-back pulses when overlapping, one otherwise
    do_reset();
    pattern = 4'b1111; overlap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("ones_ovl_dout", 32'(dout), 32'(i >= 3));
    end
    do_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ones_nonovl_pulses", 32'(pulses), 32'd1);

    // gap of invalid cycles in the middle of a pattern
    do_reset();
    pattern = 4'b1010;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_no_pulse", 32'(pulses), 32'd0);
    chk("gap_fill_held", 32'(fill), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_final_dout", 32'(dout), 32'd1);

    // clear together with the completing bit discards it
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clear_dout", 32'(dout), 32'd0);
    chk("clear_fill", 32'(fill), 32'd0);

    // reset arriving while in MATCH
    for (int i = 0; i < 4; i++) step(alt[7-i], 1'b1, 1'b0, 1'b0);
    chk("pre_reset_match", 32'(dout), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_in_match_dout", 32'(dout), 32'd0);
    chk("reset_in_match_fill", 32'(fill), 32'd0);
    chk("reset_in_match_cnt", 32'(match_count), 32'd0);

    // ten ones: the 2-bit counter saturates at 3, the 8-bit one reaches 7
    do_reset();
    pattern = 4'b1111; overlap_en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SEQDET_MATCH_CNT_EN
    chk("sat_cnt2", 32'(match_count2), 32'd3);
    chk("sat_cnt8", 32'(match_count), 32'd7);
`else
    chk("sat_cnt2", 32'(match_count2), 32'd0);
    chk("sat_cnt8", 32'(match_count), 32'd0);
`endif
    chk("sat_pulses", 32'(pulses), 32'd7);

    // randomized traffic with occasional pattern/mode changes, clears and resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 31) == 0) pattern = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) overlap_en = ~overlap_en;
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
